// File: rtl/ifu_tag_ctrl.sv
// ifu_tag_ctrl -- lookup/fill controller of the IFU instruction cache.
//
// Holds a fully associative tag/valid/data array and serves one fetch at a
// time. A hit answers in the cycle after acceptance. A miss requests the line
// from memory, installs it in the way chosen by the PLRU (evicted_cl), and
// forwards the requested word straight from the fill data.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   req_valid/addr    core fetch request (byte address, bits [1:0] ignored)
//   req_ready         high only in IDLE
//   rsp_valid/instr   one-cycle response pulse with the fetched instruction
//   mem_req_*         line fill request (valid/ready, line-aligned address)
//   mem_rsp_*         fill data return
//   cache_ctrl_plru   {update_tree, cache_miss, hit_cl} towards the PLRU
//   evicted_cl        victim way from the PLRU, used in the fill cycle
module ifu_tag_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int WAYS_NUM = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [ADDR_W-1:0]             req_addr,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_instr,
  output logic                          mem_req_valid,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [LINE_W-1:0]             mem_rsp_data,
  output logic [$clog2(WAYS_NUM)+1:0]   cache_ctrl_plru,
  input  logic [$clog2(WAYS_NUM)-1:0]   evicted_cl
);

  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int TAG_W    = ADDR_W - OFFSET_W;
  localparam int WORDS    = LINE_W / 32;
  localparam int WSEL_W   = OFFSET_W - 2;
  localparam int IDX_W    = $clog2(WAYS_NUM);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOOKUP   = 2'd1;
  localparam logic [1:0] S_MEM_REQ  = 2'd2;
  localparam logic [1:0] S_MEM_WAIT = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [ADDR_W-1:2]         addr_q, addr_d;
  logic [WAYS_NUM-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]          tag_q  [WAYS_NUM];
  logic [TAG_W-1:0]          tag_d  [WAYS_NUM];
  logic [WORDS-1:0][31:0]    data_q [WAYS_NUM];
  logic [WORDS-1:0][31:0]    data_d [WAYS_NUM];

  logic [TAG_W-1:0]          req_tag;
  logic [WSEL_W-1:0]         word_sel;
  logic [WORDS-1:0][31:0]    fill_words;
  logic                      hit;
  logic [IDX_W-1:0]          hit_idx;
  logic                      lookup_hit;
  logic                      fill;
  logic                      update_tree;
  logic                      cache_miss;
  logic [IDX_W-1:0]          hit_cl;
  logic                      unused_req_addr_lsb;

  assign unused_req_addr_lsb = ^req_addr[1:0];

  assign req_tag    = addr_q[ADDR_W-1:OFFSET_W];
  assign word_sel   = addr_q[OFFSET_W-1:2];
  assign fill_words = mem_rsp_data;

  // Tag match across all valid ways; lowest index wins should two ever match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned w = 0; w < WAYS_NUM; w++) begin
      if (!hit && valid_q[w] && (tag_q[w] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(w);
      end
    end
  end

  assign lookup_hit = (state_q == S_LOOKUP) && hit;
  assign fill       = (state_q == S_MEM_WAIT) && mem_rsp_valid;

  // Outputs are decoded from state_q so that an asynchronous reset drops
  // mem_req_valid and the PLRU controls immediately.
  always_comb begin
    req_ready     = (state_q == S_IDLE);
    rsp_valid     = lookup_hit || fill;
    rsp_instr     = '0;
    if (lookup_hit) begin
      rsp_instr = data_q[hit_idx][word_sel];
    end else if (fill) begin
      // Fill bypass: the word comes from the incoming line, not the array.
      rsp_instr = fill_words[word_sel];
    end
    mem_req_valid = (state_q == S_MEM_REQ);
    mem_req_addr  = '0;
    if (state_q == S_MEM_REQ) begin
      mem_req_addr = {req_tag, {OFFSET_W{1'b0}}};
    end
    update_tree   = lookup_hit || fill;
    cache_miss    = (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);
    hit_cl        = lookup_hit ? hit_idx : '0;
  end

  assign cache_ctrl_plru = {update_tree, cache_miss, hit_cl};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = hit ? S_IDLE : S_MEM_REQ;
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line install into the PLRU victim; an occupied way is overwritten
  // silently since instruction lines are never dirty.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d[evicted_cl] = 1'b1;
      tag_d[evicted_cl]   = req_tag;
      data_d[evicted_cl]  = fill_words;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data storage carry no reset; valid_q qualifies their contents.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_ifu_tag_ctrl.sv
// Directed bench for ifu_tag_ctrl. The bench plays both the core and the
// memory, and drives evicted_cl itself in place of the PLRU.
module tb_ifu_tag_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_instr;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic [5:0]   cache_ctrl_plru;
  logic [3:0]   evicted_cl;

  int cmp  = 0;
  int errs = 0;
  int upd_cnt  = 0;
  int mreq_cnt = 0;

  always #5 clk = ~clk;

  ifu_tag_ctrl #(.ADDR_W(32), .LINE_W(128), .WAYS_NUM(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .cache_ctrl_plru(cache_ctrl_plru), .evicted_cl(evicted_cl)
  );

  // update_tree pulses and mem request cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (cache_ctrl_plru[5]) upd_cnt++;
    if (mem_req_valid) mreq_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Line whose word k is 0xA5000000 | base | 4k, so every word names its own address.
  function automatic logic [127:0] mk_line(input logic [31:0] base);
    mk_line = {base | 32'hA500_000C, base | 32'hA500_0008, base | 32'hA500_0004, base | 32'hA500_0000};
  endfunction

  task automatic apply_reset();
    req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  // Drives one fetch to completion (no checking). Observations: hit/rsp fields
  // from the LOOKUP cycle on a hit, from the fill cycle on a miss.
  task automatic issue(input logic [31:0] addr, input logic [127:0] line, input int lat,
                       output logic hit, output logic rspv, output logic [31:0] instr,
                       output logic [3:0] way, output logic [31:0] maddr,
                       output logic upd, output logic cmiss);
    int n;
    hit = 0; rspv = 0; instr = '0; way = '0; maddr = '0; upd = 0; cmiss = 0;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    req_valid = 1'b1; req_addr = addr;
    step();
    req_valid = 1'b0; req_addr = '0;
    if (rsp_valid) begin
      hit = 1; rspv = 1; instr = rsp_instr; way = cache_ctrl_plru[3:0];
      upd = cache_ctrl_plru[5]; cmiss = cache_ctrl_plru[4];
      step();
    end else begin
      step();
      maddr = mem_req_addr; cmiss = cache_ctrl_plru[4];
      n = 0;
      while (!(mem_req_valid && mem_req_ready) && n < 20) begin step(); n++; end
      step();
      repeat (lat) step();
      mem_rsp_valid = 1'b1; mem_rsp_data = line;
      #1;
      rspv = rsp_valid; instr = rsp_instr; way = cache_ctrl_plru[3:0];
      upd = cache_ctrl_plru[5]; cmiss = cmiss & cache_ctrl_plru[4];
      step();
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; evicted_cl = '0;
    #3;
    cmp++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    cmp++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    cmp++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); end
    cmp++; if (cache_ctrl_plru !== 6'h00) begin errs++; $display("FAIL rst_plru: got %h want 00", cache_ctrl_plru); end
    cmp++; if (rsp_instr !== 32'h0) begin errs++; $display("FAIL rst_rsp_instr: got %h want 0", rsp_instr); end
    cmp++; if (mem_req_addr !== 32'h0) begin errs++; $display("FAIL rst_mem_req_addr: got %h want 0", mem_req_addr); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_cold_miss();
    logic h, rv, upd, cm; logic [31:0] ins, ma; logic [3:0] w; int u0, m0;
    evicted_cl = 4'd0; u0 = upd_cnt; m0 = mreq_cnt;
    issue(32'h0000_1004, {32'h0010_0073, 32'h0000_0093, 32'hDEAD_BEEF, 32'h0000_0013}, 3,
          h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b0) begin errs++; $display("FAIL cold_is_miss: got hit=%b want 0", h); end
    cmp++; if (ma !== 32'h0000_1000) begin errs++; $display("FAIL cold_mem_addr: got %h want 00001000", ma); end
    cmp++; if (rv !== 1'b1 || ins !== 32'hDEAD_BEEF) begin errs++; $display("FAIL cold_rsp: got v=%b %h want v=1 deadbeef", rv, ins); end
    cmp++; if (upd !== 1'b1 || cm !== 1'b1 || w !== 4'd0) begin errs++; $display("FAIL cold_plru: got upd=%b miss=%b hit_cl=%0d want 1 1 0", upd, cm, w); end
    cmp++; if (upd_cnt !== u0 + 1) begin errs++; $display("FAIL cold_upd_pulses: got %0d want %0d", upd_cnt - u0, 1); end
    cmp++; if (mreq_cnt !== m0 + 1) begin errs++; $display("FAIL cold_mem_req_cycles: got %0d want 1", mreq_cnt - m0); end
  endtask

  task automatic test_hit();
    logic h, rv, upd, cm; logic [31:0] ins, ma; logic [3:0] w; int u0, m0;
    u0 = upd_cnt; m0 = mreq_cnt;
    issue(32'h0000_100C, '0, 0, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b1 || ins !== 32'h0010_0073) begin errs++; $display("FAIL hit_rsp: got hit=%b %h want 1 00100073", h, ins); end
    cmp++; if (w !== 4'd0 || cm !== 1'b0 || upd !== 1'b1) begin errs++; $display("FAIL hit_plru: got hit_cl=%0d miss=%b upd=%b want 0 0 1", w, cm, upd); end
    cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errs++; $display("FAIL hit_back_idle: got ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid); end
    cmp++; if (mreq_cnt !== m0 || upd_cnt !== u0 + 1) begin errs++; $display("FAIL hit_counts: got mreq=%0d upd=%0d want 0 1", mreq_cnt - m0, upd_cnt - u0); end
  endtask

  task automatic test_tag_compare();
    logic h, rv, upd, cm; logic [31:0] ins, ma; logic [3:0] w;
    apply_reset();
    evicted_cl = 4'd0;
    issue(32'h0000_1000, mk_line(32'h0000_1000), 1, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b0 || ma !== 32'h0000_1000) begin errs++; $display("FAIL tag_miss_a: got hit=%b addr=%h want 0 00001000", h, ma); end
    evicted_cl = 4'd1;
    issue(32'h0001_1000, mk_line(32'h0001_1000), 1, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b0 || ma !== 32'h0001_1000) begin errs++; $display("FAIL tag_miss_b: got hit=%b addr=%h want 0 00011000", h, ma); end
    issue(32'h0000_1004, '0, 0, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b1 || w !== 4'd0 || ins !== 32'hA500_1004) begin errs++; $display("FAIL tag_hit_a: got hit=%b way=%0d %h want 1 0 a5001004", h, w, ins); end
    issue(32'h0001_1008, '0, 0, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b1 || w !== 4'd1 || ins !== 32'hA501_1008) begin errs++; $display("FAIL tag_hit_b: got hit=%b way=%0d %h want 1 1 a5011008", h, w, ins); end
  endtask

  task automatic test_fill_order();
    logic h, rv, upd, cm; logic [31:0] ins, ma, a; logic [3:0] w;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      evicted_cl = 4'(i);
      a = 32'(i * 16 + (i % 4) * 4);
      issue(a, mk_line(32'(i * 16)), 2, h, rv, ins, w, ma, upd, cm);
      cmp++; if (h !== 1'b0 || ma !== 32'(i * 16) || ins !== (32'hA500_0000 | a))
        begin errs++; $display("FAIL fill_miss_%0d: got hit=%b addr=%h %h want 0 %h %h", i, h, ma, ins, 32'(i * 16), 32'hA500_0000 | a); end
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 16 + 12);
      issue(a, '0, 0, h, rv, ins, w, ma, upd, cm);
      cmp++; if (h !== 1'b1 || w !== 4'(i) || ins !== (32'hA500_0000 | a))
        begin errs++; $display("FAIL fill_hit_%0d: got hit=%b way=%0d %h want 1 %0d %h", i, h, w, ins, i, 32'hA500_0000 | a); end
    end
    evicted_cl = 4'd5;
    issue(32'h0000_0100, mk_line(32'h0000_0100), 1, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b0 || ma !== 32'h0000_0100 || ins !== 32'hA500_0100) begin errs++; $display("FAIL full_miss: got hit=%b addr=%h %h want 0 00000100 a5000100", h, ma, ins); end
    issue(32'h0000_0108, '0, 0, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b1 || w !== 4'd5 || ins !== 32'hA500_0108) begin errs++; $display("FAIL full_hit_new: got hit=%b way=%0d %h want 1 5 a5000108", h, w, ins); end
    issue(32'h0000_0064, '0, 0, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b1 || w !== 4'd6) begin errs++; $display("FAIL full_keep_neighbour: got hit=%b way=%0d want 1 6", h, w); end
    issue(32'h0000_0054, mk_line(32'h0000_0050), 1, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b0 || ma !== 32'h0000_0050 || ins !== 32'hA500_0054) begin errs++; $display("FAIL evicted_rerequest: got hit=%b addr=%h %h want 0 00000050 a5000054", h, ma, ins); end
  endtask

  task automatic test_backpressure();
    logic h, rv, upd, cm; logic [31:0] ins, ma; logic [3:0] w; int u0;
    evicted_cl = 4'd7; u0 = upd_cnt;
    mem_req_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_2008;
    step();
    req_valid = 1'b0; req_addr = '0;
    cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errs++; $display("FAIL bp_lookup: got rsp_valid=%b ready=%b want 0 0", rsp_valid, req_ready); end
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin mem_rsp_valid = 1'b1; mem_rsp_data = '1; end
      #1;
      cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2000 || req_ready !== 1'b0 ||
                 rsp_valid !== 1'b0 || cache_ctrl_plru !== 6'h10)
        begin errs++; $display("FAIL bp_hold_%0d: got v=%b addr=%h ready=%b rsp=%b plru=%h want 1 00002000 0 0 10",
                               i, mem_req_valid, mem_req_addr, req_ready, rsp_valid, cache_ctrl_plru); end
      step();
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    end
    mem_req_ready = 1'b1;
    step();
    cmp++; if (mem_req_valid !== 1'b0 || cache_ctrl_plru !== 6'h10) begin errs++; $display("FAIL bp_wait: got v=%b plru=%h want 0 10", mem_req_valid, cache_ctrl_plru); end
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = mk_line(32'h0000_2000);
    #1;
    cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'hA500_2008) begin errs++; $display("FAIL bp_fill_rsp: got v=%b %h want 1 a5002008", rsp_valid, rsp_instr); end
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    cmp++; if (upd_cnt !== u0 + 1) begin errs++; $display("FAIL bp_upd_pulses: got %0d want 1", upd_cnt - u0); end
    issue(32'h0000_2004, '0, 0, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b1 || w !== 4'd7 || ins !== 32'hA500_2004) begin errs++; $display("FAIL bp_refetch: got hit=%b way=%0d %h want 1 7 a5002004", h, w, ins); end
  endtask

  task automatic test_reset_mid_miss();
    logic h, rv, upd, cm; logic [31:0] ins, ma; logic [3:0] w; int u0;
    evicted_cl = 4'd3;
    req_valid = 1'b1; req_addr = 32'h0000_3000;
    step();
    req_valid = 1'b0; req_addr = '0;
    step(); step();
    cmp++; if (mem_req_valid !== 1'b0 || cache_ctrl_plru !== 6'h10) begin errs++; $display("FAIL rmm_in_wait: got v=%b plru=%h want 0 10", mem_req_valid, cache_ctrl_plru); end
    u0 = upd_cnt;
    #2; rst = 1'b0; #1;
    cmp++; if (req_ready !== 1'b1 || cache_ctrl_plru !== 6'h00 || rsp_valid !== 1'b0)
      begin errs++; $display("FAIL rmm_async: got ready=%b plru=%h rsp=%b want 1 00 0", req_ready, cache_ctrl_plru, rsp_valid); end
    step();
    rst = 1'b1;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = mk_line(32'h0000_3000);
    #1;
    cmp++; if (rsp_valid !== 1'b0 || cache_ctrl_plru[5] !== 1'b0) begin errs++; $display("FAIL rmm_late_rsp: got rsp=%b upd=%b want 0 0", rsp_valid, cache_ctrl_plru[5]); end
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    cmp++; if (req_ready !== 1'b1 || upd_cnt !== u0) begin errs++; $display("FAIL rmm_idle: got ready=%b upd=%0d want 1 0", req_ready, upd_cnt - u0); end
    issue(32'h0000_3004, mk_line(32'h0000_3000), 1, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b0 || ins !== 32'hA500_3004) begin errs++; $display("FAIL rmm_same_line_miss: got hit=%b %h want 0 a5003004", h, ins); end
    evicted_cl = 4'd4;
    issue(32'h0000_2004, mk_line(32'h0000_2000), 1, h, rv, ins, w, ma, upd, cm);
    cmp++; if (h !== 1'b0 || ma !== 32'h0000_2000) begin errs++; $display("FAIL rmm_old_line_miss: got hit=%b addr=%h want 0 00002000", h, ma); end
    // Reset while the fill request is outstanding must drop it without a clock.
    req_valid = 1'b1; req_addr = 32'h0000_4000;
    mem_req_ready = 1'b0;
    step();
    req_valid = 1'b0; req_addr = '0;
    step();
    cmp++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL rmm_req_up: got %b want 1", mem_req_valid); end
    #2; rst = 1'b0; #1;
    cmp++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin errs++; $display("FAIL rmm_req_drop: got v=%b addr=%h want 0 0", mem_req_valid, mem_req_addr); end
    step();
    rst = 1'b1; mem_req_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_tag_compare();
    test_fill_order();
    test_backpressure();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
